// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serialiser states,
// register offsets from BASE_ADDR and register bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Byte offsets of the registers relative to BASE_ADDR.
  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;

  // STATUS bit positions; count occupies [STAT_CNT_LSB +: 3].
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_DONE    = 4;
  localparam int STAT_CNT_LSB = 8;

  // CTRL bit positions.
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte-wide circular FIFO with a separate occupancy counter so that full and
// empty are unambiguous. Flush empties the FIFO but leaves the head byte on
// dout_o for the current cycle, so a same-cycle pop still gets its data.
module tx_byte_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [7:0]    dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);

  // Storage write; the slot at wr_ptr_q is free (or is being vacated by a pop).
  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO, the
// serialiser drains it back-to-back, and a sticky done flag (set when the line
// goes idle) can raise irqout. STATUS is write-1-to-clear, CTRL holds irq_en.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0020,
  parameter int          CLKS_PER_BIT = 2604,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;

  logic          hit_tx, hit_stat, hit_ctrl;
  logic          push, pop, flush, frame_done, baud_end;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          unused_bus_bits;

  // Only addr[31:2] and wdata[7:0] carry meaning for this peripheral.
  assign unused_bus_bits = ^{addr[1:0], wdata[31:8]};

  assign hit_tx   = (addr[31:2] == TXDATA_ADDR[31:2]);
  assign hit_stat = (addr[31:2] == STATUS_ADDR[31:2]);
  assign hit_ctrl = (addr[31:2] == CTRL_ADDR[31:2]);
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  tx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (wdata[7:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Serialiser: pop into the shift register, then start / 8 data / stop bits.
  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d   = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
          end else begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The line level is registered from the next state so UART_TX is a clean flop output.
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
    else                         tx_d = 1'b1;
  end

  // Register writes: TXDATA push/overflow, STATUS W1C, CTRL irq_en and flush.
  always_comb begin
    push     = 1'b0;
    flush    = 1'b0;
    ovf_d    = ovf_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    if (wr && hit_tx) begin
      if (!fifo_full || pop) push  = 1'b1;
      else                   ovf_d = 1'b1;
    end
    if (wr && hit_stat) begin
      if (wdata[STAT_OVF])  ovf_d  = 1'b0;
      if (wdata[STAT_DONE]) done_d = 1'b0;
    end
    if (wr && hit_ctrl) begin
      irq_en_d = wdata[CTRL_IRQ_EN];
      flush    = wdata[CTRL_FLUSH];
    end
    // A frame finishing on the same edge as a W1C keeps done set.
    if (frame_done) done_d = 1'b1;
  end

  // Read mux; reads have no side effects and unmapped or idle bus returns 0.
  always_comb begin
    rdata = '0;
    if (rd && hit_stat) begin
      rdata[STAT_BUSY]             = (state_q != ST_IDLE);
      rdata[STAT_FULL]             = fifo_full;
      rdata[STAT_EMPTY]            = fifo_empty;
      rdata[STAT_OVF]              = ovf_q;
      rdata[STAT_DONE]             = done_q;
      rdata[STAT_CNT_LSB +: 3]     = 3'(fifo_count);
    end else if (rd && hit_ctrl) begin
      rdata[CTRL_IRQ_EN]           = irq_en_q;
    end
  end

  // State flops; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
    end
  end

  assign UART_TX = tx_q;
  assign irqout  = irq_en_q & done_q;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Memory-mapped UART transmitter on the CPU data bus, responding to the ME-stage peripheral accesses that the pipeline issues (rd/wr/addr/wdata/rdata).
- Software writes bytes into a small TX FIFO.
- An 8N1 serialiser drains the FIFO onto UART_TX.
- A sticky "drained" flag can raise irqout toward the CPU's interrupt logic.

Parameters:
- BASE_ADDR, 32'h40000020, word address of the TXDATA register. STATUS is BASE+4; CTRL is BASE+8.
- CLKS_PER_BIT, 2604, clk cycles per UART bit (25 MHz / 9600 baud).
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock (25 MHz CPU clock)
- reset  in  1  reset
- rd  in  1  bus read strobe (qualified by CPU for peripheral space)
- wr  in  1  bus write strobe
- addr  in  32  byte address; addr[1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- UART_TX  out  1  serial output, idle high
- irqout  out  1  level interrupt request

Interface (already decided): one clock, clk. Reset is named reset and is synchronous and active-high: all state clears on a clk rising edge while reset=1.

Behaviour:
- Reset values:
  - UART_TX=1, irqout=0, FIFO empty, FSM=IDLE, baud counter 0.
  - CTRL=0, overflow=0, done=0.
  - rdata follows its combinational rule.
  - Reset mid-frame aborts the frame; UART_TX is 1 on the cycle after the reset edge.
- Decode: a register hits when addr[31:2] equals its word address. Accesses to unmapped addresses: writes ignored, rdata=0.
- rdata:
  - 0 unless rd=1 and the address hits a register.
  - Read has no side effects.
- TXDATA write (wr=1):
  - Push wdata[7:0] if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the data is dropped and overflow is set.
  - TXDATA reads return 0.
- STATUS read: bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bit3 overflow, bit4 done, bits[10:8] count. All other bits 0.
- STATUS write: write-1-to-clear for bit3 and bit4.
- CTRL:
  - R/W bit0 irq_en.
  - Writing 1 to bit1 flushes the FIFO (count=0). bit1 reads as 0.
  - A flush does not abort a frame in flight.
  - Flush beats a same-cycle pop: count ends at 0, and the popped byte is still transmitted.
- irqout = irq_en & done, registered behaviour (follows the state flops, no combinational path from the bus).
- FIFO: circular buffer with read/write pointers and count register (width clog2(FIFO_DEPTH)+1). Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into an 8-bit shift register, clear the baud counter, go to START. Pop happens at the edge where IDLE sees count>0.
  - START: UART_TX=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: UART_TX=shift[0], LSB first. Every CLKS_PER_BIT cycles shift right and increment the index. After bit 7's period, go to STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles. Then:
    - if FIFO non-empty, pop and go to START directly (no idle gap);
    - else go to IDLE and set done.
- Baud counter runs 0..CLKS_PER_BIT-1. A bit period ends on the cycle where the counter equals CLKS_PER_BIT-1.
- Latency: a TXDATA write at edge N with the FSM idle and FIFO empty gives count=1 after N. The pop and UART_TX falling edge occur at edge N+1. The frame lasts exactly 10*CLKS_PER_BIT cycles.
- done set and W1C in the same cycle: set wins.
- UART_TX is driven from a flop (glitch-free).

Decomposition:
- Package uart_pkg:
  - FSM state enum (2 bits).
  - Register offsets TXDATA_OFS=0, STATUS_OFS=4, CTRL_OFS=8.
  - STATUS/CTRL bit-position constants.
- Sub-module tx_byte_fifo: synchronous FIFO with push, pop, flush, dout, count, full, empty, parameterised by FIFO_DEPTH.
- Bus decode, registers and FSM stay in the top.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: write 0x55 to TXDATA → UART_TX low 4 cycles starting one edge after the write. Data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. done=1; STATUS reads 0x014 (empty, done).
- Back-to-back: write 0xA1, 0xB2, 0xC3 consecutively → three frames with no idle gap between the stop bit and the next start bit. Total 120 cycles; decoded bytes A1, B2, C3.
- Overflow: FSM busy with byte 0x00 and 4 bytes queued, write 0xEE → dropped. STATUS bit3=1, bit1=1, count=4. Writing STATUS 0x008 clears bit3.
- Interrupt: write CTRL=1, send one byte → irqout rises the cycle after done sets. Writing STATUS 0x010 drops irqout next cycle.
- Flush mid-frame: queue 3 bytes, write CTRL=0x3 during the first frame → first frame completes, no further frames. count=0, done=1.
- Reset mid-frame: assert reset during the DATA state → UART_TX=1, STATUS reads 0x004, irqout=0. The bus is unmapped-safe (rd at BASE+12 returns 0).
